bram_block_reader: RTL and testbench

- Read-side initiator for the synchronous single-port block memory, which has a one-cycle read latency. Sits between the memory and the AES-CTR datapath.
- On a start command, streams a contiguous run of 128-bit blocks out of memory onto a valid/ready stream. Hides the read latency with an internal 4-entry buffer.
- Sustains one block per cycle while the consumer keeps ready high.

---
 rtl/bram_block_reader.sv | 138 +++++++++++++
 tb/tb_bram_block_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_block_reader.sv
// Streams a contiguous run of blocks from a 1-cycle-latency single-port memory
// onto a valid/ready stream, using a 4-entry buffer to hide the read latency.
module bram_block_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_blocks,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_WIDTH:0]   r_num;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH:0]   r_sent;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [0:3];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;

    logic w_accept;
    logic w_issue;
    logic w_push;
    logic w_pop;

    // Buffered plus in-flight words are capped at 4 so a returning read always has a slot.
    assign w_accept = (r_state == S_IDLE) && start && (num_blocks != '0);
    assign w_issue  = (r_state == S_RUN) && (r_issued < r_num)
                      && ((r_count + {2'b00, r_inflight}) < 3'd4);
    assign w_push   = r_inflight;
    assign w_pop    = m_valid && m_ready;

    assign bram_we   = 1'b0;
    assign bram_addr = r_addr;
    assign m_valid   = (r_count != 3'd0);
    assign m_data    = m_valid ? r_buf[r_rd_ptr] : '0;
    assign m_last    = m_valid && ((r_sent + (ADDR_WIDTH+1)'(1)) == r_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_blocks != '0) ? S_RUN : S_FINISH;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_pop && m_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num      <= '0;
            r_issued   <= '0;
            r_sent     <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_num    <= num_blocks;
                r_addr   <= base_addr;
                r_issued <= '0;
                r_sent   <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_issued <= r_issued + (ADDR_WIDTH+1)'(1);
            end

            r_inflight <= w_issue;

            if (w_push) begin
                r_buf[r_wr_ptr] <= bram_rdata;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_sent   <= r_sent + (ADDR_WIDTH+1)'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_block_reader.sv
// Directed bench for bram_block_reader: a queue-based reference model checked
// every cycle, plus hand-computed timing and address literals.
module tb_bram_block_reader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [7:0]   base_addr;
    logic [8:0]   num_blocks;
    logic         busy;
    logic         done;
    logic         bram_we;
    logic [7:0]   bram_addr;
    logic [127:0] bram_rdata;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_last;

    bram_block_reader #(.DATA_WIDTH(128), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_blocks (num_blocks),
        .busy       (busy),
        .done       (done),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory with mem[i] = i.
    logic [127:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 128'(i);
    end
    always @(posedge clk) bram_rdata <= mem[bram_addr];

    // Consumer ready: 0 = always, 1 = repeating 1,0,0,1, 2 = random.
    int ready_mode = 0;
    initial begin
        int rc;
        rc = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            case (ready_mode)
                1:       m_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Reference model: expected block queue and run/finish phases.
    typedef struct {
        logic [127:0] d;
        logic         last;
    } blk_t;

    blk_t         q[$];
    logic         m_run = 1'b0;
    logic         m_fin = 1'b0;
    logic [7:0]   m_base = '0;
    logic [7:0]   m_exp_addr = '0;
    int           m_popped = 0;
    int           run_xfers = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    always @(negedge clk) begin
        logic       nxt_run;
        logic       nxt_fin;
        logic [7:0] diff;
        blk_t       b;
        if (rst) begin
            q.delete();
            m_run = 1'b0;
            m_fin = 1'b0;
            m_popped = 0;
            prev_stall = 1'b0;
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_valid", m_valid, 1'b0);
            chk1("rst_last", m_last, 1'b0);
            chkw("rst_data", m_data, '0);
            chk8("rst_addr", bram_addr, 8'h00);
        end else begin
            nxt_run = m_run;
            nxt_fin = 1'b0;
            chk1("busy", busy, m_run);
            chk1("done", done, m_fin);
            chk1("we", bram_we, 1'b0);
            if (prev_stall) begin
                chk1("stall_valid", m_valid, 1'b1);
                chkw("stall_data", m_data, prev_data);
                chk1("stall_last", m_last, prev_last);
            end
            if (q.size() == 0) chk1("valid_no_data", m_valid, 1'b0);
            if (m_run) begin
                diff = bram_addr - m_base;
                chk1("outstanding_le4", (int'(diff) - m_popped) <= 4, 1'b1);
            end
            if (m_fin) chk8("final_addr", bram_addr, m_exp_addr);
            if (m_valid && m_ready && q.size() > 0) begin
                b = q.pop_front();
                chkw("stream_data", m_data, b.d);
                chk1("stream_last", m_last, b.last);
                m_popped++;
                run_xfers++;
                if (b.last) begin
                    nxt_run = 1'b0;
                    nxt_fin = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (!m_run && !m_fin && start) begin
                if (num_blocks == 9'd0) begin
                    nxt_fin    = 1'b1;
                    m_exp_addr = bram_addr;
                end else begin
                    nxt_run    = 1'b1;
                    m_base     = base_addr;
                    m_exp_addr = base_addr + num_blocks[7:0];
                    m_popped   = 0;
                    run_xfers  = 0;
                    for (int k = 0; k < int'(num_blocks); k++) begin
                        b.d    = mem[8'(int'(base_addr) + k)];
                        b.last = (k == int'(num_blocks) - 1);
                        q.push_back(b);
                    end
                end
            end
            m_run = nxt_run;
            m_fin = nxt_fin;
        end
    end

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = b;
        num_blocks = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk1("done_timeout", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a0;
        logic       reached;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        num_blocks = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Full-rate run: literal cycle timing relative to start in cycle 0.
        ready_mode = 0;
        pulse_start(8'h10, 9'd8);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk1("t1_busy", busy, (c <= 10));
            chk1("t1_done", done, (c == 11));
            chk1("t1_xfer", m_valid & m_ready, (c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) begin
                chkw("t1_data", m_data, 128'(c + 13));
                chk1("t1_last", m_last, (c == 10));
            end
        end
        repeat (2) @(posedge clk);

        // Back-pressure: fixed pattern then random stalls.
        ready_mode = 1;
        pulse_start(8'h10, 9'd8);
        wait_done(200);
        chkw("t2_count", 128'(run_xfers), 128'(8));
        ready_mode = 2;
        pulse_start(8'h10, 9'd8);
        wait_done(200);
        chkw("t2r_count", 128'(run_xfers), 128'(8));
        repeat (2) @(posedge clk);

        // Address wrap.
        ready_mode = 0;
        pulse_start(8'hFE, 9'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) chk8("t3_addr1", bram_addr, 8'hFE);
            if (c == 2) chk8("t3_addr2", bram_addr, 8'hFF);
            if (c == 3) chk8("t3_addr3", bram_addr, 8'h00);
            if (c == 4) chk8("t3_addr4", bram_addr, 8'h01);
            if (c == 3) chkw("t3_data3", m_data, 128'h0FE);
            if (c == 4) chkw("t3_data4", m_data, 128'h0FF);
            if (c == 5) chkw("t3_data5", m_data, 128'h000);
            if (c == 6) chkw("t3_data6", m_data, 128'h001);
            chk1("t3_done", done, (c == 7));
        end
        repeat (2) @(posedge clk);

        // Zero-length run.
        a0 = bram_addr;
        pulse_start(8'h40, 9'd0);
        @(negedge clk);
        chk1("t4_done", done, 1'b1);
        chk1("t4_busy", busy, 1'b0);
        chk1("t4_valid", m_valid, 1'b0);
        chk8("t4_addr", bram_addr, a0);
        @(negedge clk);
        chk1("t4_done_once", done, 1'b0);
        repeat (2) @(posedge clk);

        // Second start during a run is ignored.
        ready_mode = 1;
        pulse_start(8'h20, 9'd8);
        repeat (3) @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = 8'h80;
        num_blocks = 9'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200);
        chkw("t5_count", 128'(run_xfers), 128'(8));
        repeat (6) @(posedge clk);

        // Asynchronous reset after three blocks, then a fresh run.
        ready_mode = 0;
        pulse_start(8'h30, 9'd8);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(posedge clk);
            if (run_xfers >= 3) reached = 1'b1;
        end
        chk1("t6_reach3", reached, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_done", done, 1'b0);
        chk1("t6_valid", m_valid, 1'b0);
        chk1("t6_last", m_last, 1'b0);
        chkw("t6_data", m_data, '0);
        chk8("t6_addr", bram_addr, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        pulse_start(8'h50, 9'd3);
        wait_done(100);
        chkw("t6_count", 128'(run_xfers), 128'(3));
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
